// File: rtl/i2c_slave.sv
// Single-byte I2C target: oversamples sclk/sda on clk, matches an 8-bit LSB-first
// address, then receives or transmits one byte before waiting for stop/start.
module i2c_slave #(
  parameter logic [7:0] SLAVE_ADDRESS = 8'hee
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       sclk,
  input  logic       sda_in,
  output logic       sda_out,
  input  logic       rw,
  input  logic [7:0] tx_data,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  output logic       busy,
  output logic [2:0] state
);

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    ADDR = 3'd1,
    ACK  = 3'd2,
    RX   = 3'd3,
    TX   = 3'd4,
    DONE = 3'd5
  } state_t;

  state_t     state_r, state_next_s;
  logic       sclk_meta_r, sclk_sync_r, sclk_hist_r;
  logic       sda_meta_r, sda_sync_r, sda_hist_r;
  logic [2:0] bit_cnt_r, bit_cnt_next_s;
  logic       bit_term_r, bit_term_next_s;
  logic [7:0] addr_r, addr_next_s;
  logic [7:0] shift_r, shift_next_s;
  logic [7:0] tx_shift_r;
  logic       rw_r;
  logic       sda_out_r, sda_next_s;
  logic [7:0] rx_data_r;
  logic       rx_valid_r, rx_load_s;
  logic       busy_r, busy_next_s;
  logic       capture_s;
  logic       sclk_rise_s, sclk_fall_s, start_s, stop_s, match_s;

  assign sclk_rise_s = sclk_sync_r & ~sclk_hist_r;
  assign sclk_fall_s = ~sclk_sync_r & sclk_hist_r;
  assign start_s     = sclk_sync_r & sclk_hist_r & sda_hist_r & ~sda_sync_r;
  assign stop_s      = sclk_sync_r & sclk_hist_r & ~sda_hist_r & sda_sync_r;
  // The incoming bit is the address MSB, so the match uses it directly.
  assign match_s     = ({sda_sync_r, addr_r[6:0]} == SLAVE_ADDRESS);

  assign sda_out  = sda_out_r;
  assign rx_data  = rx_data_r;
  assign rx_valid = rx_valid_r;
  assign busy     = busy_r;
  assign state    = state_r;

  // Two-flop synchronizers plus one history flop per bus line
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sclk_meta_r <= 1'b0;
      sclk_sync_r <= 1'b0;
      sclk_hist_r <= 1'b0;
      sda_meta_r  <= 1'b0;
      sda_sync_r  <= 1'b0;
      sda_hist_r  <= 1'b0;
    end else begin
      sclk_meta_r <= sclk;
      sclk_sync_r <= sclk_meta_r;
      sclk_hist_r <= sclk_sync_r;
      sda_meta_r  <= sda_in;
      sda_sync_r  <= sda_meta_r;
      sda_hist_r  <= sda_sync_r;
    end
  end

  // FSM state register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_next_s;
    end
  end

  // FSM next-state logic; start and stop override every state
  always_comb begin
    state_next_s = state_r;
    if (start_s) begin
      state_next_s = ADDR;
    end else if (stop_s) begin
      state_next_s = IDLE;
    end else begin
      case (state_r)
        IDLE: state_next_s = IDLE;
        ADDR: begin
          if (sclk_rise_s && (bit_cnt_r == 3'd7)) begin
            state_next_s = match_s ? ACK : DONE;
          end else begin
            state_next_s = ADDR;
          end
        end
        ACK: begin
          if (sclk_fall_s && (bit_cnt_r == 3'd2)) begin
            state_next_s = rw_r ? TX : RX;
          end else begin
            state_next_s = ACK;
          end
        end
        RX: begin
          if (sclk_rise_s && (bit_cnt_r == 3'd7)) begin
            state_next_s = DONE;
          end else begin
            state_next_s = RX;
          end
        end
        TX: begin
          if (sclk_fall_s && bit_term_r) begin
            state_next_s = DONE;
          end else begin
            state_next_s = TX;
          end
        end
        DONE:    state_next_s = DONE;
        default: state_next_s = IDLE;
      endcase
    end
  end

  // FSM output/datapath logic; in ACK the bit counter tracks fall/rise/fall phases
  always_comb begin
    sda_next_s      = sda_out_r;
    bit_cnt_next_s  = bit_cnt_r;
    bit_term_next_s = bit_term_r;
    addr_next_s     = addr_r;
    shift_next_s    = shift_r;
    busy_next_s     = busy_r;
    rx_load_s       = 1'b0;
    capture_s       = 1'b0;
    if (start_s) begin
      sda_next_s      = 1'b1;
      bit_cnt_next_s  = 3'd0;
      bit_term_next_s = 1'b0;
      addr_next_s     = 8'h00;
      busy_next_s     = 1'b1;
    end else if (stop_s) begin
      sda_next_s      = 1'b1;
      bit_cnt_next_s  = 3'd0;
      bit_term_next_s = 1'b0;
      busy_next_s     = 1'b0;
    end else begin
      case (state_r)
        IDLE: sda_next_s = 1'b1;
        ADDR: begin
          if (sclk_rise_s) begin
            addr_next_s[bit_cnt_r] = sda_sync_r;
            if (bit_cnt_r == 3'd7) begin
              bit_cnt_next_s = 3'd0;
              capture_s      = match_s;
              sda_next_s     = 1'b1;
            end else begin
              bit_cnt_next_s = bit_cnt_r + 3'd1;
            end
          end else begin
            addr_next_s = addr_r;
          end
        end
        ACK: begin
          if (sclk_fall_s && (bit_cnt_r == 3'd0)) begin
            sda_next_s     = 1'b0;
            bit_cnt_next_s = 3'd1;
          end else if (sclk_rise_s && (bit_cnt_r == 3'd1)) begin
            bit_cnt_next_s = 3'd2;
          end else if (sclk_fall_s && (bit_cnt_r == 3'd2)) begin
            bit_cnt_next_s  = 3'd0;
            bit_term_next_s = 1'b0;
            sda_next_s      = rw_r ? tx_shift_r[0] : 1'b1;
          end else begin
            bit_cnt_next_s = bit_cnt_r;
          end
        end
        RX: begin
          if (sclk_rise_s) begin
            shift_next_s[bit_cnt_r] = sda_sync_r;
            if (bit_cnt_r == 3'd7) begin
              bit_cnt_next_s = 3'd0;
              rx_load_s      = 1'b1;
            end else begin
              bit_cnt_next_s = bit_cnt_r + 3'd1;
            end
          end else begin
            shift_next_s = shift_r;
          end
        end
        TX: begin
          if (sclk_fall_s) begin
            if (bit_term_r) begin
              sda_next_s      = 1'b1;
              bit_term_next_s = 1'b0;
            end else begin
              sda_next_s = tx_shift_r[bit_cnt_r];
            end
          end else if (sclk_rise_s) begin
            if (bit_cnt_r == 3'd7) begin
              bit_term_next_s = 1'b1;
            end else begin
              bit_cnt_next_s = bit_cnt_r + 3'd1;
            end
          end else begin
            sda_next_s = sda_out_r;
          end
        end
        DONE:    sda_next_s = 1'b1;
        default: sda_next_s = 1'b1;
      endcase
    end
  end

  // Datapath and registered outputs
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sda_out_r  <= 1'b1;
      bit_cnt_r  <= 3'd0;
      bit_term_r <= 1'b0;
      addr_r     <= 8'h00;
      shift_r    <= 8'h00;
      tx_shift_r <= 8'h00;
      rw_r       <= 1'b0;
      rx_data_r  <= 8'h00;
      rx_valid_r <= 1'b0;
      busy_r     <= 1'b0;
    end else begin
      sda_out_r  <= sda_next_s;
      bit_cnt_r  <= bit_cnt_next_s;
      bit_term_r <= bit_term_next_s;
      addr_r     <= addr_next_s;
      shift_r    <= shift_next_s;
      busy_r     <= busy_next_s;
      rx_valid_r <= rx_load_s;
      if (capture_s) begin
        tx_shift_r <= tx_data;
        rw_r       <= rw;
      end else begin
        tx_shift_r <= tx_shift_r;
        rw_r       <= rw_r;
      end
      if (rx_load_s) begin
        rx_data_r <= shift_next_s;
      end else begin
        rx_data_r <= rx_data_r;
      end
    end
  end

endmodule
